alu_pipe: RTL and testbench

//  Parametrised, registered ALU with valid/ready handshakes on input and output.

---
 rtl/alu_pipe.sv | 179 +++++++++++++++++
 tb/tb_alu_pipe.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_pipe.sv
// Registered ALU with valid/ready handshakes on both sides.
// Single-cycle ops complete in one clock; MUL is a WIDTH-iteration shift-add.
module alu_pipe #(
   parameter  int WIDTH = 8,
   localparam int SHW   = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [2:0]       opcode,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             carry_out,
   output logic             zero,
   output logic             negative,
   output logic             overflow
);

   typedef enum logic [1:0] {S_IDLE = 2'd0, S_MUL = 2'd1, S_DONE = 2'd2} state_t;

   localparam logic [2:0] OP_ADD = 3'b000;
   localparam logic [2:0] OP_SUB = 3'b001;
   localparam logic [2:0] OP_AND = 3'b010;
   localparam logic [2:0] OP_OR  = 3'b011;
   localparam logic [2:0] OP_XOR = 3'b100;
   localparam logic [2:0] OP_SHL = 3'b101;
   localparam logic [2:0] OP_SHR = 3'b110;
   localparam logic [2:0] OP_MUL = 3'b111;

   localparam logic [SHW:0] MUL_ITERS = (SHW+1)'(WIDTH);

   state_t             state_q, state_d;
   logic [WIDTH-1:0]   result_q, result_d;
   logic               carry_q, carry_d;
   logic               ovf_q, ovf_d;
   logic               zero_q, zero_d;
   logic               neg_q, neg_d;
   logic [2*WIDTH-1:0] acc_q, acc_d;
   logic [2*WIDTH-1:0] mcand_q, mcand_d;
   logic [WIDTH-1:0]   mplier_q, mplier_d;
   logic [SHW:0]       cnt_q, cnt_d;

   logic               accept;
   logic [SHW-1:0]     shamt;
   logic [WIDTH:0]     sum, diff, shl_ext, shr_ext;
   logic [WIDTH-1:0]   alu_res;
   logic               alu_c, alu_v;

   assign in_ready  = (state_q == S_IDLE) | ((state_q == S_DONE) & out_ready);
   assign accept    = in_valid & in_ready;
   assign out_valid = (state_q == S_DONE);
   assign result    = result_q;
   assign carry_out = carry_q;
   assign overflow  = ovf_q;
   assign zero      = zero_q;
   assign negative  = neg_q;

   // One extra bit on each shift keeps the last bit shifted out.
   always_comb begin
      shamt   = b[SHW-1:0];
      sum     = {1'b0, a} + {1'b0, b};
      diff    = {1'b0, a} - {1'b0, b};
      shl_ext = {1'b0, a} << shamt;
      shr_ext = {a, 1'b0} >> shamt;
      alu_res = '0;
      alu_c   = 1'b0;
      alu_v   = 1'b0;
      case (opcode)
         OP_ADD: begin
            alu_res = sum[WIDTH-1:0];
            alu_c   = sum[WIDTH];
            alu_v   = (a[WIDTH-1] == b[WIDTH-1]) & (sum[WIDTH-1] != a[WIDTH-1]);
         end
         OP_SUB: begin
            alu_res = diff[WIDTH-1:0];
            alu_c   = diff[WIDTH];
            alu_v   = (a[WIDTH-1] != b[WIDTH-1]) & (diff[WIDTH-1] != a[WIDTH-1]);
         end
         OP_AND: alu_res = a & b;
         OP_OR:  alu_res = a | b;
         OP_XOR: alu_res = a ^ b;
         OP_SHL: begin
            alu_res = shl_ext[WIDTH-1:0];
            alu_c   = shl_ext[WIDTH];
         end
         OP_SHR: begin
            alu_res = shr_ext[WIDTH:1];
            alu_c   = shr_ext[0];
         end
         default: ;
      endcase
   end

   always_comb begin
      state_d  = state_q;
      result_d = result_q;
      carry_d  = carry_q;
      ovf_d    = ovf_q;
      zero_d   = zero_q;
      neg_d    = neg_q;
      acc_d    = acc_q;
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      cnt_d    = cnt_q;

      case (state_q)
         S_MUL: begin
            if (cnt_q == MUL_ITERS) begin
               state_d  = S_DONE;
               result_d = acc_q[WIDTH-1:0];
               carry_d  = |acc_q[2*WIDTH-1:WIDTH];
               ovf_d    = 1'b0;
               zero_d   = (acc_q[WIDTH-1:0] == '0);
               neg_d    = acc_q[WIDTH-1];
            end else begin
               if (mplier_q[0])
                  acc_d = acc_q + mcand_q;
               mcand_d  = mcand_q << 1;
               mplier_d = mplier_q >> 1;
               cnt_d    = cnt_q + 1'b1;
            end
         end
         S_DONE: begin
            if (out_ready)
               state_d = S_IDLE;
         end
         default: ;
      endcase

      // A new beat can only arrive from IDLE or a draining DONE, so it wins.
      if (accept) begin
         if (opcode == OP_MUL) begin
            state_d  = S_MUL;
            acc_d    = '0;
            mcand_d  = {{WIDTH{1'b0}}, a};
            mplier_d = b;
            cnt_d    = '0;
         end else begin
            state_d  = S_DONE;
            result_d = alu_res;
            carry_d  = alu_c;
            ovf_d    = alu_v;
            zero_d   = (alu_res == '0);
            neg_d    = alu_res[WIDTH-1];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_IDLE;
         result_q <= '0;
         carry_q  <= 1'b0;
         ovf_q    <= 1'b0;
         zero_q   <= 1'b0;
         neg_q    <= 1'b0;
         acc_q    <= '0;
         mcand_q  <= '0;
         mplier_q <= '0;
         cnt_q    <= '0;
      end else begin
         state_q  <= state_d;
         result_q <= result_d;
         carry_q  <= carry_d;
         ovf_q    <= ovf_d;
         zero_q   <= zero_d;
         neg_q    <= neg_d;
         acc_q    <= acc_d;
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         cnt_q    <= cnt_d;
      end
   end

endmodule

// File: tb/tb_alu_pipe.sv
// Scoreboard bench for alu_pipe: driver pushes expected results, monitor pops on output handshake.
module tb_alu_pipe;

   localparam logic [2:0] ADD = 3'b000, SUB = 3'b001, ANDO = 3'b010, ORO = 3'b011,
                          XORO = 3'b100, SHL = 3'b101, SHR = 3'b110, MUL = 3'b111;

   typedef struct packed {
      logic [7:0] res;
      logic       c;
      logic       v;
      logic       z;
      logic       n;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] a_i, b_i;
   logic [2:0] op_i;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] result;
   logic       carry_out, zero, negative, overflow;

   logic       dir_ready, rnd_ready, rnd_mode;
   int         checks = 0;
   int         fails  = 0;
   exp_t       sb[$];
   exp_t       mon_e;

   assign out_ready = rnd_mode ? rnd_ready : dir_ready;

   always #5 clk = ~clk;

   alu_pipe #(.WIDTH(8)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .a(a_i), .b(b_i), .opcode(op_i), .out_valid(out_valid), .out_ready(out_ready),
      .result(result), .carry_out(carry_out), .zero(zero), .negative(negative),
      .overflow(overflow)
   );

   function automatic exp_t mk(input logic [7:0] r, input logic c, input logic v);
      exp_t e;
      e.res = r;
      e.c   = c;
      e.v   = v;
      e.z   = (r == 8'h00);
      e.n   = r[7];
      return e;
   endfunction

   // Reference model built from plain full-width arithmetic.
   function automatic exp_t model(input logic [7:0] ta, input logic [7:0] tb_v, input logic [2:0] op);
      logic [8:0]  s;
      logic [15:0] p;
      int          sh;
      logic [7:0]  r;
      logic        c, v;
      sh = int'(tb_v[2:0]);
      r = 8'h00; c = 1'b0; v = 1'b0;
      case (op)
         ADD: begin s = {1'b0, ta} + {1'b0, tb_v}; r = s[7:0]; c = s[8];
                    v = (ta[7] == tb_v[7]) && (r[7] != ta[7]); end
         SUB: begin r = ta - tb_v; c = (ta < tb_v); v = (ta[7] != tb_v[7]) && (r[7] != ta[7]); end
         ANDO: r = ta & tb_v;
         ORO:  r = ta | tb_v;
         XORO: r = ta ^ tb_v;
         SHL: begin r = ta << sh; c = (sh == 0) ? 1'b0 : ta[8-sh]; end
         SHR: begin r = ta >> sh; c = (sh == 0) ? 1'b0 : ta[sh-1]; end
         default: begin p = ta * tb_v; r = p[7:0]; c = |p[15:8]; end
      endcase
      return mk(r, c, v);
   endfunction

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] req);
      checks++;
      if (got !== req) begin
         fails++;
         $display("FAIL %s: got %0h, required %0h", name, got, req);
      end else
         $display("ok   %s: %0h", name, got);
   endtask

   task automatic send(input logic [7:0] ta, input logic [7:0] tb_v, input logic [2:0] op, input exp_t e);
      int n;
      a_i = ta; b_i = tb_v; op_i = op; in_valid = 1'b1; n = 0;
      @(negedge clk);
      while (!in_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) begin
         checks++;
         fails++;
         $display("FAIL send_timeout: in_ready got 0 after %0d cycles, required 1", n);
      end else
         sb.push_back(e);
      @(posedge clk);
      #1 in_valid = 1'b0;
   endtask

   always @(negedge clk) begin
      if (!rst && out_valid && out_ready) begin
         checks++;
         if (sb.size() == 0) begin
            fails++;
            $display("FAIL unexpected_output: got result=%h, required no output", result);
         end else begin
            mon_e = sb.pop_front();
            if ({result, carry_out, overflow, zero, negative} !== {mon_e.res, mon_e.c, mon_e.v, mon_e.z, mon_e.n}) begin
               fails++;
               $display("FAIL result: got res=%h c=%b v=%b z=%b n=%b, required res=%h c=%b v=%b z=%b n=%b",
                        result, carry_out, overflow, zero, negative,
                        mon_e.res, mon_e.c, mon_e.v, mon_e.z, mon_e.n);
            end else
               $display("ok   result: res=%h c=%b v=%b z=%b n=%b", result, carry_out, overflow, zero, negative);
         end
      end
   end

   initial begin
      rnd_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1 rnd_ready = 1'($urandom_range(0, 1));
      end
   end

   initial begin
      int         lat;
      logic       bad_ir, bad_ov, bad_hold;
      logic [7:0] ra, rb;
      logic [2:0] rop;

      rst = 1'b1; in_valid = 1'b0; a_i = '0; b_i = '0; op_i = '0;
      dir_ready = 1'b1; rnd_mode = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("reset_out_valid", 32'(out_valid), 0);
      chk("reset_result", 32'(result), 0);
      chk("reset_in_ready", 32'(in_ready), 1);
      chk("reset_flags", 32'({carry_out, zero, negative, overflow}), 0);
      @(posedge clk); #1;

      // Directed vectors, back to back with the consumer always ready.
      send(8'hFF, 8'h01, ADD,  mk(8'h00, 1'b1, 1'b0));
      send(8'h7F, 8'h01, ADD,  mk(8'h80, 1'b0, 1'b1));
      send(8'h03, 8'h05, SUB,  mk(8'hFE, 1'b1, 1'b0));
      send(8'h80, 8'h01, SUB,  mk(8'h7F, 1'b0, 1'b1));
      send(8'h81, 8'h01, SHL,  mk(8'h02, 1'b1, 1'b0));
      send(8'h81, 8'h00, SHR,  mk(8'h81, 1'b0, 1'b0));
      send(8'h81, 8'h01, SHR,  mk(8'h40, 1'b1, 1'b0));
      send(8'h0F, 8'h04, SHL,  mk(8'hF0, 1'b0, 1'b0));
      send(8'hF0, 8'h3C, ANDO, mk(8'h30, 1'b0, 1'b0));
      send(8'hF0, 8'h0F, ORO,  mk(8'hFF, 1'b0, 1'b0));
      send(8'hAA, 8'hAA, XORO, mk(8'h00, 1'b0, 1'b0));
      send(8'h05, 8'h03, MUL,  mk(8'h0F, 1'b0, 1'b0));
      repeat (12) @(posedge clk);
      #1;

      send(8'h20, 8'h22, ADD, mk(8'h42, 1'b0, 1'b0));
      @(negedge clk);
      chk("add_latency_out_valid", 32'(out_valid), 1);
      @(posedge clk); #1;

      // MUL latency and in_ready held low throughout.
      send(8'h10, 8'h11, MUL, mk(8'h10, 1'b1, 1'b0));
      lat = -1; bad_ir = 1'b0;
      for (int k = 1; k <= 20; k++) begin
         @(negedge clk);
         if (out_valid) begin
            lat = k - 1;
            break;
         end
         if (in_ready) bad_ir = 1'b1;
      end
      chk("mul_latency", 32'(lat), 9);
      chk("mul_in_ready_low", 32'(bad_ir), 0);
      repeat (2) @(posedge clk);
      #1;

      // Backpressure: result must hold while a competing beat is offered.
      dir_ready = 1'b0;
      send(8'h12, 8'h34, ADD, mk(8'h46, 1'b0, 1'b0));
      a_i = 8'hFF; b_i = 8'hFF; op_i = SUB; in_valid = 1'b1;
      bad_ov = 1'b0; bad_ir = 1'b0; bad_hold = 1'b0;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         if (!out_valid) bad_ov = 1'b1;
         if (in_ready) bad_ir = 1'b1;
         if ({result, carry_out, overflow, zero, negative} !== {8'h46, 4'b0000}) bad_hold = 1'b1;
      end
      chk("stall_out_valid_held", 32'(bad_ov), 0);
      chk("stall_in_ready_low", 32'(bad_ir), 0);
      chk("stall_result_held", 32'(bad_hold), 0);
      @(posedge clk);
      #1 in_valid = 1'b0; dir_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;

      // Random beats against the model with a random consumer.
      rnd_mode = 1'b1;
      for (int i = 0; i < 20; i++) begin
         ra  = 8'($urandom);
         rb  = 8'($urandom);
         rop = 3'($urandom_range(0, 7));
         send(ra, rb, rop, model(ra, rb, rop));
      end
      for (int k = 0; k < 500 && sb.size() != 0; k++)
         @(posedge clk);
      chk("random_drain_empty", 32'(sb.size()), 0);
      @(posedge clk);
      #1 rnd_mode = 1'b0;
      repeat (2) @(posedge clk);
      #1;

      // Reset in the middle of a multiply abandons it.
      send(8'h0F, 8'h0F, MUL, mk(8'hE1, 1'b0, 1'b0));
      repeat (3) @(posedge clk);
      #1 rst = 1'b1;
      sb.delete();
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("midmul_reset_out_valid", 32'(out_valid), 0);
      chk("midmul_reset_result", 32'(result), 0);
      chk("midmul_reset_in_ready", 32'(in_ready), 1);
      bad_ov = 1'b0;
      for (int k = 0; k < 15; k++) begin
         @(negedge clk);
         if (out_valid) bad_ov = 1'b1;
      end
      chk("midmul_no_result", 32'(bad_ov), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
